// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receive framer: synchronises the raw lines, deserialises 11-bit frames and
// folds E0/F0 prefixes into a 9-bit make code. Optional parity check: define PS2_PARITY_CHECK_EN.
module ps2_rx_framer #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] CODE,
  output logic       CODE_VALID,
  output logic       ERR
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t      state, state_nx;
  logic        c1, c2, c3, d1, d2, d3;
  logic        fall;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic        ext_flag, brk_flag;
  logic [15:0] wd;
  logic        wd_hit, par_ok;
  logic        start, shift, frame_done, err_ev;

  // fall is registered so the edge reaches the FSM 3 cycles after the raw edge;
  // d3 keeps the data line aligned with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      {c1, c2, c3} <= '1;
      {d1, d2, d3} <= '1;
      fall         <= 1'b0;
    end else begin
      c1   <= ps2_clk;
      c2   <= c1;
      c3   <= c2;
      fall <= c3 & ~c2;
      d1   <= ps2_data;
      d2   <= d1;
      d3   <= d2;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par;

  always_ff @(posedge clock) begin
    if (!reset_n)                     par <= 1'b0;
    else if (state == PARITY && fall) par <= d3;
  end

  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif

  assign wd_hit = (wd == 16'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    shift      = 1'b0;
    frame_done = 1'b0;
    err_ev     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          if (!d3) begin
            state_nx = DATA;
            start    = 1'b1;
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift = 1'b1;
          if (bitcnt == 3'd7) state_nx = PARITY;
        end else if (wd_hit) begin
          state_nx = IDLE;
          err_ev   = 1'b1;
        end
      end
      PARITY: begin
        if (fall) begin
          state_nx = STOP;
        end else if (wd_hit) begin
          state_nx = IDLE;
          err_ev   = 1'b1;
        end
      end
      STOP: begin
        if (fall) begin
          state_nx = IDLE;
          if (d3 && par_ok) frame_done = 1'b1;
          else              err_ev     = 1'b1;
        end else if (wd_hit) begin
          state_nx = IDLE;
          err_ev   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shreg      <= '0;
      bitcnt     <= '0;
      wd         <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      CODE       <= '0;
      CODE_VALID <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      CODE_VALID <= 1'b0;
      ERR        <= err_ev;

      if (start) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (shift) begin
        shreg  <= {d3, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end

      if (fall || state_nx == IDLE) wd <= '0;
      else                          wd <= wd + 16'd1;

      if (err_ev) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (frame_done) begin
        case (shreg)
          8'hE0:   ext_flag <= 1'b1;
          8'hF0:   brk_flag <= 1'b1;
          default: begin
            if (!brk_flag) begin
              CODE       <= {ext_flag, shreg};
              CODE_VALID <= 1'b1;
            end
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
